// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM arbiter; display reads win every slot, CPU writes are posted
// through a small FIFO and CPU reads wait until that FIFO has drained.
module vram_arbiter #(
  parameter int AddrBits  = 16,
  parameter int FifoDepth = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         disp_req,
  input  logic [AddrBits-1:0]          disp_addr,
  output logic                         disp_valid,
  output logic [7:0]                   disp_data,
  input  logic                         cpu_valid,
  input  logic                         cpu_we,
  input  logic [AddrBits-1:0]          cpu_addr,
  input  logic [7:0]                   cpu_wdata,
  output logic                         cpu_ready,
  output logic                         cpu_rvalid,
  output logic [7:0]                   cpu_rdata,
  output logic [$clog2(FifoDepth):0]   fifo_level,
  output logic [AddrBits-1:0]          ram_addr,
  output logic                         ram_we,
  output logic [7:0]                   ram_din,
  input  logic [7:0]                   ram_dout
);
  localparam int PW = $clog2(FifoDepth);
  localparam logic [1:0] IDLE = 2'd0, RD_PEND = 2'd1, RD_DATA = 2'd2;
  logic [AddrBits-1:0] fa_q [FifoDepth];
  logic [7:0]          fd_q [FifoDepth];
  logic [PW-1:0]       wp_q, rp_q;
  logic [PW:0]         lvl_q;
  logic [1:0]          state_q, state_d;
  logic [AddrBits-1:0] rd_addr_q, last_addr_q;
  logic                disp_valid_q, rvalid_q;
  logic [7:0]          rdata_q;
  logic                g_fifo, g_rd, push, rd_acc;
  assign g_fifo     = !disp_req && lvl_q != '0;
  assign g_rd       = !disp_req && lvl_q == '0 && state_q == RD_PEND;
  assign cpu_ready  = state_q == IDLE && (!cpu_we || lvl_q != (PW+1)'(FifoDepth));
  assign push       = cpu_valid && cpu_ready && cpu_we;
  assign rd_acc     = cpu_valid && cpu_ready && !cpu_we;
  assign ram_we     = g_fifo;
  assign ram_din    = fd_q[rp_q];
  assign ram_addr   = disp_req ? disp_addr : g_fifo ? fa_q[rp_q] : g_rd ? rd_addr_q : last_addr_q;
  assign fifo_level = lvl_q;
  assign disp_valid = disp_valid_q;
  assign disp_data  = ram_dout;
  assign cpu_rvalid = rvalid_q;
  // While the pulse is high the RAM is still presenting the read word; the register holds it afterwards.
  assign cpu_rdata  = rvalid_q ? ram_dout : rdata_q;
  always_comb begin
    state_d = state_q == IDLE    ? (rd_acc ? RD_PEND : IDLE) :
              state_q == RD_PEND ? (g_rd ? RD_DATA : RD_PEND) : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q         <= '0;
      rp_q         <= '0;
      lvl_q        <= '0;
      state_q      <= IDLE;
      rd_addr_q    <= '0;
      last_addr_q  <= '0;
      disp_valid_q <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      disp_valid_q <= disp_req;
      rvalid_q     <= g_rd;
      last_addr_q  <= ram_addr;
      if (rvalid_q) rdata_q <= ram_dout;
      if (rd_acc) rd_addr_q <= cpu_addr;
      if (push) wp_q <= wp_q + PW'(1);
      if (g_fifo) rp_q <= rp_q + PW'(1);
      lvl_q <= lvl_q + (PW+1)'(push) - (PW+1)'(g_fifo);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      fa_q[wp_q] <= cpu_addr;
      fd_q[wp_q] <= cpu_wdata;
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: vector table, directed corner cases and randomized traffic checked by a
// transaction-level model (posted-write queue, read-expectation queue, shadow memory).
module tb_vram_arbiter;
  logic        clk, reset, disp_req, disp_valid, cpu_valid, cpu_we, cpu_ready, cpu_rvalid, ram_we;
  logic [15:0] disp_addr, cpu_addr, ram_addr;
  logic [7:0]  disp_data, cpu_wdata, cpu_rdata, ram_din, ram_dout;
  logic [2:0]  fifo_level;
  logic [7:0]  ram [65536];
  logic [7:0]  ref_mem [65536];
  int          tests = 0, fails = 0;
  logic        prev_disp = 1'b0;
  typedef struct { logic [15:0] a; logic [7:0] d; } wr_t;
  typedef struct {
    logic disp, v, we; logic [15:0] a; logic [7:0] d;
    logic rdy, rwe; logic [15:0] raddr; int lvl; logic dv, rv;
  } vec_t;
  wr_t        wq[$];
  logic [7:0] rq[$];
  vec_t       tbl[10];

  vram_arbiter #(.AddrBits(16), .FifoDepth(4)) dut (
    .clk(clk), .reset(reset), .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_valid(disp_valid), .disp_data(disp_data), .cpu_valid(cpu_valid), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata), .fifo_level(fifo_level), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM with 1-cycle read latency
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  task automatic chk(input string n, input int a, input int e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: writes land in acceptance order, reads see all earlier writes.
  always @(negedge clk) begin
    if (reset) begin
      wq.delete();
      rq.delete();
      ref_mem = ram;
      prev_disp = 1'b0;
    end else begin
      chk("disp_valid", disp_valid, prev_disp);
      chk("fifo_level", fifo_level, wq.size());
      if (disp_req) begin
        chk("disp_addr", ram_addr, disp_addr);
        chk("disp_no_we", ram_we, 0);
      end
      if (ram_we) begin
        chk("we_pending", int'(wq.size() > 0), 1);
        if (wq.size() > 0) begin
          chk("wr_addr", ram_addr, wq[0].a);
          chk("wr_data", ram_din, wq[0].d);
          void'(wq.pop_front());
        end
      end
      if (cpu_rvalid) begin
        chk("rvalid_pending", int'(rq.size() > 0), 1);
        if (rq.size() > 0) chk("rdata", cpu_rdata, rq.pop_front());
      end
      if (cpu_valid && cpu_ready) begin
        if (cpu_we) begin
          wq.push_back('{cpu_addr, cpu_wdata});
          ref_mem[cpu_addr] = cpu_wdata;
        end else rq.push_back(ref_mem[cpu_addr]);
      end
      prev_disp = disp_req;
    end
  end

  task automatic cpu_cmd(input logic we, input logic [15:0] a, input logic [7:0] d);
    int n = 0;
    cpu_valid = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    #1;
    while (!cpu_ready && n < 200) begin
      cyc();
      #1;
      n++;
    end
    chk("cmd_accept_timeout", int'(n < 200), 1);
    cyc();
    cpu_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    disp_req = 1'b0; cpu_valid = 1'b0; cpu_we = 1'b0;
    repeat (n) cyc();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; disp_req = 1'b0; disp_addr = '0; cpu_valid = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    for (int i = 0; i < 65536; i++) begin
      ram[i] <= 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    ram[16'h0400] <= 8'h3E;
    ref_mem[16'h0400] = 8'h3E;
    tbl[0] = '{0, 1, 1, 16'h0010, 8'h11, 1, 0, 16'h0000, 0, 0, 0};
    tbl[1] = '{1, 1, 1, 16'h0020, 8'h22, 1, 0, 16'h8000, 1, 0, 0};
    tbl[2] = '{1, 0, 0, 16'h0020, 8'h00, 1, 0, 16'h8000, 2, 1, 0};
    tbl[3] = '{0, 0, 0, 16'h0020, 8'h00, 1, 1, 16'h0010, 2, 1, 0};
    tbl[4] = '{0, 0, 0, 16'h0020, 8'h00, 1, 1, 16'h0020, 1, 0, 0};
    tbl[5] = '{0, 0, 0, 16'h0020, 8'h00, 1, 0, 16'h0020, 0, 0, 0};
    tbl[6] = '{0, 1, 0, 16'h0020, 8'h00, 1, 0, 16'h0020, 0, 0, 0};
    tbl[7] = '{0, 0, 0, 16'h0020, 8'h00, 0, 0, 16'h0020, 0, 0, 0};
    tbl[8] = '{0, 0, 0, 16'h0020, 8'h00, 0, 0, 16'h0020, 0, 0, 1};
    tbl[9] = '{0, 0, 0, 16'h0020, 8'h00, 1, 0, 16'h0020, 0, 0, 0};
    cyc(); cyc();
    #1;
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_rvalid", cpu_rvalid, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_level", fifo_level, 0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      disp_req = tbl[i].disp; disp_addr = 16'h8000; cpu_valid = tbl[i].v; cpu_we = tbl[i].we;
      cpu_addr = tbl[i].a; cpu_wdata = tbl[i].d;
      #1;
      chk($sformatf("v%0d_ready", i), cpu_ready, tbl[i].rdy);
      chk($sformatf("v%0d_ram_we", i), ram_we, tbl[i].rwe);
      chk($sformatf("v%0d_ram_addr", i), ram_addr, tbl[i].raddr);
      chk($sformatf("v%0d_level", i), fifo_level, tbl[i].lvl);
      chk($sformatf("v%0d_disp_valid", i), disp_valid, tbl[i].dv);
      chk($sformatf("v%0d_rvalid", i), cpu_rvalid, tbl[i].rv);
      cyc();
    end
    idle(4);
    // Best-case read latency
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0400;
    #1; chk("lat_accept", cpu_ready, 1);
    cyc(); cpu_valid = 1'b0;
    #1; chk("lat_n1_rvalid", cpu_rvalid, 0); chk("lat_n1_addr", ram_addr, 16'h0400);
    cyc();
    #1; chk("lat_n2_rvalid", cpu_rvalid, 1); chk("lat_n2_rdata", cpu_rdata, 8'h3E);
    chk("lat_n2_ready", cpu_ready, 0);
    cyc();
    #1; chk("lat_n3_rvalid", cpu_rvalid, 0); chk("lat_n3_ready", cpu_ready, 1);
    chk("lat_n3_rdata", cpu_rdata, 8'h3E);
    idle(4);
    // Display priority over a posted write
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0123; cpu_wdata = 8'hAA;
    disp_req = 1'b1; disp_addr = 16'h1000;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("prio_no_we", ram_we, 0);
      if (i == 0) chk("prio_accept", cpu_ready, 1);
      cyc();
      cpu_valid = 1'b0;
    end
    disp_req = 1'b0;
    #1; chk("prio_we", ram_we, 1); chk("prio_addr", ram_addr, 16'h0123); chk("prio_din", ram_din, 8'hAA);
    idle(4);
    // FIFO full under continuous display traffic
    disp_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h3000 + 16'(i); cpu_wdata = 8'h40 + 8'(i);
      #1;
      if (i < 4) begin
        chk("full_ready", cpu_ready, 1);
        cyc();
      end else begin
        chk("full_level", fifo_level, 4);
        chk("full_ready5", cpu_ready, 0);
      end
    end
    cyc();
    #1; chk("full_hold", cpu_ready, 0);
    cyc();
    disp_req = 1'b0;
    #1; chk("full_drain_we", ram_we, 1); chk("full_drain_addr", ram_addr, 16'h3000);
    chk("full_drain_ready", cpu_ready, 0);
    cyc();
    #1; chk("full_lvl3", fifo_level, 3); chk("full_ready_again", cpu_ready, 1);
    cyc(); cpu_valid = 1'b0;
    #1; chk("full_push_pop", fifo_level, 3);
    idle(8);
    // Read after write
    cpu_cmd(1'b1, 16'h2000, 8'h5C);
    cpu_cmd(1'b0, 16'h2000, 8'h00);
    n = 0;
    #1;
    while (!cpu_rvalid && n < 50) begin
      cyc();
      #1;
      n++;
    end
    chk("raw_timeout", int'(n < 50), 1);
    chk("raw_rdata", cpu_rdata, 8'h5C);
    chk("raw_mem", ram[16'h2000], 8'h5C);
    idle(4);
    // Reset with a pending read and two posted writes
    disp_req = 1'b1; disp_addr = 16'h1234;
    cpu_cmd(1'b1, 16'h6000, 8'h11);
    cpu_cmd(1'b1, 16'h6001, 8'h22);
    cpu_cmd(1'b0, 16'h6000, 8'h00);
    #1; chk("rstA_pre_level", fifo_level, 2); chk("rstA_pre_ready", cpu_ready, 0);
    reset = 1'b1; disp_req = 1'b0;
    #1;
    chk("rstA_disp_valid", disp_valid, 0); chk("rstA_rvalid", cpu_rvalid, 0);
    chk("rstA_rdata", cpu_rdata, 0); chk("rstA_ram_we", ram_we, 0); chk("rstA_level", fifo_level, 0);
    cyc(); cyc();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1; chk("rstA_post_we", ram_we, 0); chk("rstA_post_rvalid", cpu_rvalid, 0);
      cyc();
    end
    // Reset while the read data is being returned
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0400;
    cyc(); cpu_valid = 1'b0;
    cyc();
    #1; chk("rstB_pre_rvalid", cpu_rvalid, 1);
    reset = 1'b1;
    #1; chk("rstB_rvalid", cpu_rvalid, 0); chk("rstB_rdata", cpu_rdata, 0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1; chk("rstB_post_rvalid", cpu_rvalid, 0);
      cyc();
    end
    // Randomized traffic: pointer wrap, ordering, reads behind posted writes
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          disp_req = ($urandom_range(0, 2) == 0);
          disp_addr = 16'($urandom);
          cyc();
        end
        disp_req = 1'b0;
      end
      begin
        for (int i = 0; i < 48; i++) begin
          cpu_cmd(i % 4 != 3, 16'h5000 + 16'($urandom_range(0, 7)), 8'($urandom));
          repeat ($urandom_range(0, 2)) cyc();
        end
      end
    join
    idle(10);
    chk("drain_writes", wq.size(), 0);
    chk("drain_reads", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
